// File: rtl/cdr_pkg.sv
// CDR lock controller shared types.
// State encoding and DLF gain codes.
package cdr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQ_FAST,
        ACQ_SLOW,
        LOCKED
    } cdr_state_e;

    localparam logic [1:0] GAIN_FAST  = 2'd2;
    localparam logic [1:0] GAIN_SLOW  = 2'd1;
    localparam logic [1:0] GAIN_TRACK = 2'd0;

endpackage

// File: rtl/cdr_win_integrator.sv
// Box-car window integrator for voted Up/Dn decisions.
// Counts the window, accumulates the signed net, reports it at window end.
module cdr_win_integrator #(
    parameter int WINDOW_LEN = 64,
    parameter int NW         = $clog2(WINDOW_LEN) + 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 clr,
    input  logic                 vote_up,
    input  logic                 vote_dn,
    output logic                 win_end,
    output logic signed [NW-1:0] win_sum,
    output logic signed [NW-1:0] win_net
);

    localparam int CW = $clog2(WINDOW_LEN);
    localparam logic [CW-1:0] LAST = CW'(WINDOW_LEN - 1);

    logic [CW-1:0]        win_cnt;
    logic signed [NW-1:0] acc;
    logic signed [NW-1:0] step;

    // Per-cycle contribution, running sum including it, window-end strobe
    always_comb begin
        step = '0;
        if (vote_up && !vote_dn) begin
            step = {{(NW-1){1'b0}}, 1'b1};
        end else if (vote_dn && !vote_up) begin
            step = '1;
        end
        win_sum = acc + step;
        win_end = run && (win_cnt == LAST);
    end

    // Window counter and accumulator; restart on state change or when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt <= '0;
            acc     <= '0;
            win_net <= '0;
        end else begin
            if (win_end) begin
                win_net <= win_sum;
            end
            if (clr || !run) begin
                win_cnt <= '0;
                acc     <= '0;
            end else if (win_end) begin
                win_cnt <= '0;
                acc     <= '0;
            end else begin
                win_cnt <= win_cnt + 1'b1;
                acc     <= win_sum;
            end
        end
    end

endmodule

// File: rtl/cdr_lock_ctrl.sv
// CDR acquisition/lock sequencer.
// Steps DLF gain fast -> slow -> track and tracks lock from window nets.
module cdr_lock_ctrl
    import cdr_pkg::*;
#(
    parameter int WINDOW_LEN     = 64,
    parameter int FAST_WINDOWS   = 4,
    parameter int LOCK_THRESH    = 4,
    parameter int LOCK_WINDOWS   = 8,
    parameter int UNLOCK_THRESH  = 16,
    parameter int UNLOCK_WINDOWS = 2,
    parameter int ACQ_TIMEOUT    = 256
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 enable,
    input  logic                                 vote_up,
    input  logic                                 vote_dn,
    output logic [1:0]                           gain_sel,
    output logic                                 dlf_freeze,
    output logic                                 cdr_locked,
    output logic                                 lock_lost,
    output logic                                 acq_timeout,
    output logic signed [$clog2(WINDOW_LEN)+1:0] win_net
);

    localparam int NW   = $clog2(WINDOW_LEN) + 2;
    localparam int GW   = $clog2(LOCK_WINDOWS + 1);
    localparam int BW   = $clog2(UNLOCK_WINDOWS + 1);
    localparam int TMAX = (ACQ_TIMEOUT > FAST_WINDOWS) ?
                          ACQ_TIMEOUT : FAST_WINDOWS;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic signed [NW-1:0] LT = NW'(LOCK_THRESH);
    localparam logic signed [NW-1:0] UT = NW'(UNLOCK_THRESH);

    cdr_state_e           state;
    cdr_state_e           nxt;
    logic [GW-1:0]        good_cnt;
    logic [BW-1:0]        bad_cnt;
    logic [TW-1:0]        win_total;
    logic                 win_end;
    logic signed [NW-1:0] win_sum;
    logic                 good;
    logic                 bad;
    logic                 clr;
    logic                 run;
    logic                 lost;
    logic                 to_flag;

    cdr_win_integrator #(
        .WINDOW_LEN (WINDOW_LEN),
        .NW         (NW)
    ) u_win (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .clr     (clr),
        .vote_up (vote_up),
        .vote_dn (vote_dn),
        .win_end (win_end),
        .win_sum (win_sum),
        .win_net (win_net)
    );

    // Next state from the completed window net; enable low overrides all
    always_comb begin
        good    = (win_sum <= LT) && (win_sum >= -LT);
        bad     = (win_sum > UT) || (win_sum < -UT);
        nxt     = state;
        to_flag = 1'b0;
        if (!enable) begin
            nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: nxt = ACQ_FAST;
                ACQ_FAST: begin
                    if (win_end && win_total == TW'(FAST_WINDOWS - 1))
                        nxt = ACQ_SLOW;
                end
                ACQ_SLOW: begin
                    if (win_end) begin
                        if (good && good_cnt == GW'(LOCK_WINDOWS - 1)) begin
                            nxt = LOCKED;
                        end else if (win_total == TW'(ACQ_TIMEOUT - 1)) begin
                            nxt     = ACQ_FAST;
                            to_flag = 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (win_end && bad && bad_cnt == BW'(UNLOCK_WINDOWS - 1))
                        nxt = ACQ_FAST;
                end
                default: nxt = IDLE;
            endcase
        end
        clr  = (nxt != state);
        run  = (state != IDLE);
        lost = (state == LOCKED) && (nxt == ACQ_FAST);
    end

    // State, lock counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gain_sel    <= GAIN_FAST;
            dlf_freeze  <= 1'b1;
            cdr_locked  <= 1'b0;
            lock_lost   <= 1'b0;
            acq_timeout <= 1'b0;
            good_cnt    <= '0;
            bad_cnt     <= '0;
            win_total   <= '0;
        end else begin
            state      <= nxt;
            lock_lost  <= lost;
            dlf_freeze <= (nxt == IDLE);
            cdr_locked <= (nxt == LOCKED);
            if (to_flag) begin
                acq_timeout <= 1'b1;
            end
            case (nxt)
                ACQ_SLOW: gain_sel <= GAIN_SLOW;
                LOCKED:   gain_sel <= GAIN_TRACK;
                default:  gain_sel <= GAIN_FAST;
            endcase
            if (clr) begin
                good_cnt  <= '0;
                bad_cnt   <= '0;
                win_total <= '0;
            end else if (win_end) begin
                case (state)
                    ACQ_FAST: win_total <= win_total + 1'b1;
                    ACQ_SLOW: begin
                        good_cnt  <= good ? good_cnt + 1'b1 : '0;
                        win_total <= win_total + 1'b1;
                    end
                    LOCKED: bad_cnt <= bad ? bad_cnt + 1'b1 : '0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cdr_lock_ctrl.sv
// Testbench for cdr_lock_ctrl.
// Window table plus hand sequences; expectations queued by cycle.
module tb_cdr_lock_ctrl;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic              vote_up;
    logic              vote_dn;
    logic [1:0]        gain_sel;
    logic              dlf_freeze;
    logic              cdr_locked;
    logic              lock_lost;
    logic              acq_timeout;
    logic signed [7:0] win_net;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int    cyc;
        string nm;
        int    g;
        bit    lk;
        bit    lo;
        bit    tm;
        bit    fz;
        bit    cn;
        int    nt;
    } exp_t;

    typedef struct {
        string nm;
        int    u;
        int    d;
        int    b;
        int    net;
        int    g;
        bit    lk;
        bit    lo;
    } win_t;

    exp_t q[$];
    win_t tbl[26];

    cdr_lock_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .vote_up     (vote_up),
        .vote_dn     (vote_dn),
        .gain_sel    (gain_sel),
        .dlf_freeze  (dlf_freeze),
        .cdr_locked  (cdr_locked),
        .lock_lost   (lock_lost),
        .acq_timeout (acq_timeout),
        .win_net     (win_net)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic expect_at(input int c, input string nm, input int g,
                             input bit lk, input bit lo, input bit tm,
                             input bit fz, input bit cn, input int nt);
        exp_t e;
        e.cyc = c; e.nm = nm; e.g = g; e.lk = lk; e.lo = lo;
        e.tm = tm; e.fz = fz; e.cn = cn; e.nt = nt;
        q.push_back(e);
    endtask

    // Scoreboard: pop expectations due at this cycle, away from the edge
    always @(posedge clk) begin
        #1;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc != cyc) begin
                total++;
                bad++;
                $display("FAIL %s: due at cycle %0d, seen at %0d", e.nm, e.cyc, cyc);
            end else begin
                check({e.nm, ".gain"}, int'(gain_sel), e.g);
                check({e.nm, ".locked"}, int'(cdr_locked), int'(e.lk));
                check({e.nm, ".lost"}, int'(lock_lost), int'(e.lo));
                check({e.nm, ".tmo"}, int'(acq_timeout), int'(e.tm));
                check({e.nm, ".freeze"}, int'(dlf_freeze), int'(e.fz));
                if (e.cn) check({e.nm, ".net"}, int'(win_net), e.nt);
            end
        end
    end

    function automatic win_t mk(input string nm, input int u, input int d,
                                input int b, input int net, input int g,
                                input bit lk, input bit lo);
        win_t w;
        w.nm = nm; w.u = u; w.d = d; w.b = b;
        w.net = net; w.g = g; w.lk = lk; w.lo = lo;
        return w;
    endfunction

    // One 64-cycle window: u ups, then d downs, then b both, rest none
    task automatic drive_win(input int u, input int d, input int b, input bit alt);
        for (int p = 0; p < 64; p++) begin
            if (alt) begin
                vote_up = (p % 2 == 0);
                vote_dn = (p % 2 == 1);
            end else begin
                vote_up = (p < u) || (p >= u + d && p < u + d + b);
                vote_dn = (p >= u && p < u + d + b);
            end
            @(posedge clk);
            #1;
        end
        vote_up = 1'b0;
        vote_dn = 1'b0;
    endtask

    initial begin
        int e0, ws, t, d, r0, e1;

        tbl[0] = mk("lk_both",    0, 0, 64, 0,   0, 1, 0);
        tbl[1] = mk("lk_m16",     0, 16, 0, -16, 0, 1, 0);
        tbl[2] = mk("lk_m17",     0, 17, 0, -17, 0, 1, 0);
        tbl[3] = mk("lk_recover", 2, 0, 0,  2,   0, 1, 0);
        tbl[4] = mk("lk_bad1",    20, 0, 0, 20,  0, 1, 0);
        tbl[5] = mk("lk_bad2",    20, 0, 0, 20,  2, 0, 1);
        for (int i = 6; i < 9; i++) tbl[i] = mk("fast", 0, 0, 0, 0, 2, 0, 0);
        tbl[9]  = mk("fast_last",  0, 0, 0, 0, 1, 0, 0);
        tbl[10] = mk("slow_both",  0, 0, 64, 0, 1, 0, 0);
        for (int i = 11; i < 17; i++) tbl[i] = mk("slow_p4", 4, 0, 0, 4, 1, 0, 0);
        tbl[17] = mk("slow_p5",    5, 0, 0, 5, 1, 0, 0);
        tbl[18] = mk("slow_both2", 0, 0, 64, 0, 1, 0, 0);
        for (int i = 19; i < 25; i++) tbl[i] = mk("slow_p4b", 4, 0, 0, 4, 1, 0, 0);
        tbl[25] = mk("slow_lock",  4, 0, 0, 4, 0, 1, 0);

        rst_n   = 1'b0;
        enable  = 1'b0;
        vote_up = 1'b0;
        vote_dn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.gain", int'(gain_sel), 2);
        check("rst.freeze", int'(dlf_freeze), 1);
        check("rst.locked", int'(cdr_locked), 0);
        check("rst.lost", int'(lock_lost), 0);
        check("rst.tmo", int'(acq_timeout), 0);
        check("rst.net", int'(win_net), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Balanced lock from enable
        enable = 1'b1;
        e0 = cyc + 1;
        expect_at(e0,       "bal_start", 2, 0, 0, 0, 0, 0, 0);
        expect_at(e0 + 255, "bal_fast",  2, 0, 0, 0, 0, 0, 0);
        expect_at(e0 + 256, "bal_slow",  1, 0, 0, 0, 0, 0, 0);
        expect_at(e0 + 767, "bal_prelk", 1, 0, 0, 0, 0, 0, 0);
        expect_at(e0 + 768, "bal_lock",  0, 1, 0, 0, 0, 1, 0);
        @(posedge clk);
        #1;
        for (int w = 0; w < 12; w++) drive_win(0, 0, 0, 1'b1);

        // Threshold, loss-of-lock and re-acquisition windows
        for (int i = 0; i < 26; i++) begin
            ws = cyc;
            expect_at(ws + 64, tbl[i].nm, tbl[i].g, tbl[i].lk, tbl[i].lo,
                      0, 0, 1, tbl[i].net);
            expect_at(ws + 65, {tbl[i].nm, "+1"}, tbl[i].g, tbl[i].lk, 1'b0,
                      0, 0, 1, tbl[i].net);
            drive_win(tbl[i].u, tbl[i].d, tbl[i].b, 1'b0);
        end

        // Enable low while locked, then re-enable
        t = cyc;
        expect_at(t + 5, "pre_dis", 0, 1, 0, 0, 0, 0, 0);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        enable = 1'b0;
        d = cyc + 1;
        expect_at(d,     "dis",      2, 0, 0, 0, 1, 0, 0);
        expect_at(d + 2, "dis_hold", 2, 0, 0, 0, 1, 1, 4);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        enable = 1'b1;
        r0 = cyc + 1;
        expect_at(r0,      "reen",      2, 0, 0, 0, 0, 1, 4);
        expect_at(r0 + 63, "reen_mid",  2, 0, 0, 0, 0, 1, 4);
        expect_at(r0 + 64, "reen_win",  2, 0, 0, 0, 0, 1, 3);
        @(posedge clk);
        #1;
        drive_win(3, 0, 0, 1'b0);

        // Asynchronous reset mid-window
        vote_up = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        vote_up = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("arst.gain", int'(gain_sel), 2);
        check("arst.freeze", int'(dlf_freeze), 1);
        check("arst.locked", int'(cdr_locked), 0);
        check("arst.net", int'(win_net), 0);
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Biased acquisition: never locks, times out
        enable = 1'b1;
        e1 = cyc + 1;
        expect_at(e1,         "bias_start", 2, 0, 0, 0, 0, 0, 0);
        expect_at(e1 + 256,   "bias_slow",  1, 0, 0, 0, 0, 0, 0);
        expect_at(e1 + 8000,  "bias_mid",   1, 0, 0, 0, 0, 1, 10);
        expect_at(e1 + 16639, "bias_pre",   1, 0, 0, 0, 0, 1, 10);
        expect_at(e1 + 16640, "bias_tmo",   2, 0, 0, 1, 0, 1, 10);
        expect_at(e1 + 16641, "bias_stky",  2, 0, 0, 1, 0, 1, 10);
        @(posedge clk);
        #1;
        for (int w = 0; w < 260; w++) drive_win(10, 0, 0, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #1;

        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            total++;
            bad++;
            $display("FAIL %s: expectation for cycle %0d never sampled", e.nm, e.cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
